am_align_ctl: RTL and testbench

Closed-loop image-alignment sequencer for one motor axis. It consumes the per-frame qualified image result (pulse, signed step, ok, should_start) produced by the image/motor-state qualifier. From that result it issues a motor move, waits for the motor to finish and for stale frames to drain, then repeats until the image reports aligned, the iteration budget runs out, a frame timeout expires, or software aborts. It sits between the image-result qualifier and the per-axis motor driver inside the fusion CPU block.

---
 rtl/am_align_pkg.sv | 26 ++
 rtl/am_align_ctl_if.sv | 48 ++++
 rtl/am_step_abs_sat.sv | 35 +++
 rtl/am_align_ctl.sv | 213 +++++++++++++++++++++
 tb/tb_am_align_ctl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/am_align_pkg.sv
// ============================================================================
// Module  : am_align_pkg
// Brief   : Shared types and constants for the image-alignment sequencer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package am_align_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_IMG  = 3'd1,
        MOVE_REQ  = 3'd2,
        MOVE_WAIT = 3'd3,
        SETTLE    = 3'd4,
        DONE      = 3'd5
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_ITER    = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

`default_nettype wire

// File: rtl/am_align_ctl_if.sv
// ============================================================================
// Module  : am_align_ctl_if
// Brief   : Control, image-result and motor bundle of one alignment axis.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface am_align_ctl_if #(
    parameter int C_STEP_NUMBER_WIDTH = 32,
    parameter int C_ITER_WIDTH        = 8,
    parameter int C_TIMEOUT_WIDTH     = 16
);
    logic                                  start;
    logic                                  abort;
    logic [C_ITER_WIDTH-1:0]               max_iter;
    logic [C_TIMEOUT_WIDTH-1:0]            timeout_frames;
    logic                                  img_pulse;
    logic signed [C_STEP_NUMBER_WIDTH-1:0] img_step;
    logic                                  img_ok;
    logic                                  img_should_start;
    logic                                  m_state;
    logic                                  m_start;
    logic                                  m_stop;
    logic                                  m_dir;
    logic [C_STEP_NUMBER_WIDTH-1:0]        m_step;
    logic                                  req_dep_img;
    logic                                  busy;
    logic                                  done;
    logic                                  result_ok;
    logic [1:0]                            err_code;
    logic [C_ITER_WIDTH-1:0]               iter_cnt;

    modport master (
        output start, abort, max_iter, timeout_frames,
        output img_pulse, img_step, img_ok, img_should_start, m_state,
        input  m_start, m_stop, m_dir, m_step, req_dep_img,
        input  busy, done, result_ok, err_code, iter_cnt
    );

    modport slave (
        input  start, abort, max_iter, timeout_frames,
        input  img_pulse, img_step, img_ok, img_should_start, m_state,
        output m_start, m_stop, m_dir, m_step, req_dep_img,
        output busy, done, result_ok, err_code, iter_cnt
    );
endinterface

`default_nettype wire

// File: rtl/am_step_abs_sat.sv
// ============================================================================
// Module  : am_step_abs_sat
// Brief   : Signed step to direction + saturated unsigned magnitude.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module am_step_abs_sat #(
    parameter int C_STEP_NUMBER_WIDTH = 32
) (
    input  logic signed [C_STEP_NUMBER_WIDTH-1:0] i_step,
    output logic                                  o_dir,
    output logic        [C_STEP_NUMBER_WIDTH-1:0] o_mag
);
    localparam int W = C_STEP_NUMBER_WIDTH;
    localparam logic [W-1:0] C_MOST_NEG = {1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0] C_MAX_POS  = {1'b0, {(W-1){1'b1}}};

    logic [W-1:0] w_raw;
    assign w_raw = i_step;

    // The most-negative value has no positive twin, so clamp it to max positive.
    always_comb begin
        o_dir = w_raw[W-1];
        if (!w_raw[W-1]) begin
            o_mag = w_raw;
        end else if (w_raw == C_MOST_NEG) begin
            o_mag = C_MAX_POS;
        end else begin
            o_mag = ~w_raw + W'(1);
        end
    end
endmodule

`default_nettype wire

// File: rtl/am_align_ctl.sv
// ============================================================================
// Module  : am_align_ctl
// Brief   : Closed-loop image-alignment sequencer for one motor axis.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module am_align_ctl #(
    parameter int C_STEP_NUMBER_WIDTH = 32,
    parameter int C_ITER_WIDTH        = 8,
    parameter int C_TIMEOUT_WIDTH     = 16,
    parameter int C_SETTLE_FRAMES     = 2,
    parameter int C_ACK_CYCLES        = 16
) (
    input  logic          clk,
    input  logic          reset,
    am_align_ctl_if.slave bus
);
    import am_align_pkg::*;

    localparam int W       = C_STEP_NUMBER_WIDTH;
    localparam int C_ACK_W = (C_ACK_CYCLES > 1) ? $clog2(C_ACK_CYCLES) : 1;
    localparam int C_SET_W = (C_SETTLE_FRAMES > 1) ? $clog2(C_SETTLE_FRAMES) : 1;
    localparam logic [C_ACK_W-1:0] C_ACK_LAST =
        C_ACK_W'((C_ACK_CYCLES > 0) ? C_ACK_CYCLES - 1 : 0);
    localparam logic [C_SET_W-1:0] C_SET_LAST =
        C_SET_W'((C_SETTLE_FRAMES > 0) ? C_SETTLE_FRAMES - 1 : 0);

    state_t                      r_state;
    state_t                      w_nxt;
    logic [C_ITER_WIDTH-1:0]     r_max_iter;
    logic [C_TIMEOUT_WIDTH-1:0]  r_to_lim;
    logic [C_TIMEOUT_WIDTH-1:0]  r_to_cnt;
    logic [C_TIMEOUT_WIDTH-1:0]  w_to_inc;
    logic signed [W-1:0]         r_step_cap;
    logic [C_ACK_W-1:0]          r_ack_cnt;
    logic                        r_seen_hi;
    logic [C_SET_W-1:0]          r_settle_cnt;

    logic                        r_m_start;
    logic                        r_m_stop;
    logic                        r_m_dir;
    logic [W-1:0]                r_m_step;
    logic                        r_req_dep_img;
    logic                        r_busy;
    logic                        r_done;
    logic                        r_result_ok;
    logic [1:0]                  r_err_code;
    logic [C_ITER_WIDTH-1:0]     r_iter_cnt;

    logic                        w_dir;
    logic [W-1:0]                w_mag;
    logic                        w_iter_hit;
    logic                        w_to_hit;
    logic                        w_ack_to;
    logic                        w_motor_done;
    logic                        w_settled;

    am_step_abs_sat #(
        .C_STEP_NUMBER_WIDTH(W)
    ) u_abs_sat (
        .i_step(r_step_cap),
        .o_dir (w_dir),
        .o_mag (w_mag)
    );

    assign w_to_inc     = r_to_cnt + C_TIMEOUT_WIDTH'(1);
    assign w_iter_hit   = (r_iter_cnt == r_max_iter);
    assign w_to_hit     = (r_to_lim != '0) && (w_to_inc == r_to_lim);
    // A motor that never acknowledges is treated as a zero-length move.
    assign w_ack_to     = !r_seen_hi && !bus.m_state && (r_ack_cnt == C_ACK_LAST);
    assign w_motor_done = (r_seen_hi && !bus.m_state) || w_ack_to;
    assign w_settled    = (C_SETTLE_FRAMES == 0) ||
                          (bus.img_pulse && (r_settle_cnt == C_SET_LAST));

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) w_nxt = WAIT_IMG;
            end
            WAIT_IMG: begin
                if (bus.abort) begin
                    w_nxt = DONE;
                end else if (bus.img_pulse) begin
                    if (bus.img_ok)                 w_nxt = DONE;
                    else if (bus.img_should_start)  w_nxt = w_iter_hit ? DONE : MOVE_REQ;
                    else if (w_to_hit)              w_nxt = DONE;
                end
            end
            MOVE_REQ:  w_nxt = bus.abort ? DONE : MOVE_WAIT;
            MOVE_WAIT: begin
                if (bus.abort)         w_nxt = DONE;
                else if (w_motor_done) w_nxt = SETTLE;
            end
            SETTLE: begin
                if (bus.abort)      w_nxt = DONE;
                else if (w_settled) w_nxt = WAIT_IMG;
            end
            DONE:    w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_max_iter    <= '0;
            r_to_lim      <= '0;
            r_to_cnt      <= '0;
            r_step_cap    <= '0;
            r_ack_cnt     <= '0;
            r_seen_hi     <= 1'b0;
            r_settle_cnt  <= '0;
            r_m_start     <= 1'b0;
            r_m_stop      <= 1'b0;
            r_m_dir       <= 1'b0;
            r_m_step      <= '0;
            r_req_dep_img <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result_ok   <= 1'b0;
            r_err_code    <= ERR_NONE;
            r_iter_cnt    <= '0;
        end else begin
            r_state       <= w_nxt;
            r_m_start     <= 1'b0;
            r_m_stop      <= 1'b0;
            r_done        <= 1'b0;
            r_req_dep_img <= (w_nxt == WAIT_IMG) || (w_nxt == SETTLE);
            // busy stays up through the done cycle and drops one cycle later
            r_busy        <= (w_nxt != IDLE) || (r_state == DONE);

            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_iter_cnt  <= '0;
                        r_result_ok <= 1'b0;
                        r_err_code  <= ERR_NONE;
                        r_to_cnt    <= '0;
                        r_max_iter  <= bus.max_iter;
                        r_to_lim    <= bus.timeout_frames;
                    end
                end
                WAIT_IMG: begin
                    if (bus.abort) begin
                        r_err_code  <= ERR_ABORT;
                        r_result_ok <= 1'b0;
                    end else if (bus.img_pulse) begin
                        r_step_cap <= bus.img_step;
                        if (bus.img_ok) begin
                            r_result_ok <= 1'b1;
                        end else if (bus.img_should_start) begin
                            if (w_iter_hit) r_err_code <= ERR_ITER;
                        end else begin
                            r_to_cnt <= w_to_inc;
                            if (w_to_hit) r_err_code <= ERR_TIMEOUT;
                        end
                    end
                end
                MOVE_REQ: begin
                    r_ack_cnt <= '0;
                    r_seen_hi <= 1'b0;
                    if (bus.abort) begin
                        r_m_stop    <= 1'b1;
                        r_err_code  <= ERR_ABORT;
                        r_result_ok <= 1'b0;
                    end else begin
                        r_m_start  <= 1'b1;
                        r_m_dir    <= w_dir;
                        r_m_step   <= w_mag;
                        r_iter_cnt <= r_iter_cnt + C_ITER_WIDTH'(1);
                    end
                end
                MOVE_WAIT: begin
                    r_settle_cnt <= '0;
                    if (bus.abort) begin
                        r_m_stop    <= 1'b1;
                        r_err_code  <= ERR_ABORT;
                        r_result_ok <= 1'b0;
                    end else begin
                        if (bus.m_state) r_seen_hi <= 1'b1;
                        if (r_ack_cnt != C_ACK_LAST) r_ack_cnt <= r_ack_cnt + C_ACK_W'(1);
                    end
                end
                SETTLE: begin
                    if (bus.abort) begin
                        r_err_code  <= ERR_ABORT;
                        r_result_ok <= 1'b0;
                    end else begin
                        if (bus.img_pulse) r_settle_cnt <= r_settle_cnt + C_SET_W'(1);
                        if (w_settled)     r_to_cnt     <= '0;
                    end
                end
                DONE:    r_done <= 1'b1;
                default: ;
            endcase
        end
    end

    assign bus.m_start     = r_m_start;
    assign bus.m_stop      = r_m_stop;
    assign bus.m_dir       = r_m_dir;
    assign bus.m_step      = r_m_step;
    assign bus.req_dep_img = r_req_dep_img;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.result_ok   = r_result_ok;
    assign bus.err_code    = r_err_code;
    assign bus.iter_cnt    = r_iter_cnt;
endmodule

`default_nettype wire

// File: tb/tb_am_align_ctl.sv
// ============================================================================
// Module  : tb_am_align_ctl
// Brief   : Self-checking bench for am_align_ctl against a frame-level model.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_am_align_ctl;
    localparam int W = 32, IW = 8, TW = 16, SETTLE_N = 2, ACK_N = 16;

    typedef struct {
        bit                 ok;
        bit                 ss;
        logic signed [31:0] step;
    } frame_t;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    frame_t frame_q[$];

    always #5 clk = ~clk;

    am_align_ctl_if #(.C_STEP_NUMBER_WIDTH(W), .C_ITER_WIDTH(IW), .C_TIMEOUT_WIDTH(TW)) bus ();

    am_align_ctl #(
        .C_STEP_NUMBER_WIDTH(W), .C_ITER_WIDTH(IW), .C_TIMEOUT_WIDTH(TW),
        .C_SETTLE_FRAMES(SETTLE_N), .C_ACK_CYCLES(ACK_N)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Magnitude the motor should see: |step|, clamped to the largest positive value.
    function automatic longint sat_mag(input logic signed [31:0] s);
        longint v;
        v = s;
        if (v < 0) v = -v;
        if (v > 64'sd2147483647) v = 64'sd2147483647;
        return v;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        f.ok = ($urandom_range(0, 99) < 12);
        f.ss = ($urandom_range(0, 99) < 55);
        case ($urandom_range(0, 4))
            0:       f.step = 32'sh80000000;
            1:       f.step = 32'sd0;
            2:       f.step = 32'($urandom_range(0, 200)) - 32'd100;
            default: f.step = $urandom;
        endcase
        return f;
    endfunction

    task automatic drive_idle();
        bus.start = 0; bus.abort = 0; bus.max_iter = '0; bus.timeout_frames = '0;
        bus.img_pulse = 0; bus.img_step = '0; bus.img_ok = 0; bus.img_should_start = 0;
        bus.m_state = 0;
    endtask

    // Starts a run and feeds frames; every consumed frame is predicted by the model.
    task automatic run_frames(input int max_it, input int to_lim, input int cap,
                              input bit rnd, input bit with_abort);
        int exp_iter, to_cnt, nfr, st_cyc, dn_cyc;
        bit fin, st_seen, dn_seen, st_dir, dn_ok, busy_after;
        bit exp_done, exp_ok, exp_start;
        logic [1:0] exp_err, dn_err;
        logic [31:0] st_step;
        logic [7:0] dn_iter;
        frame_t f;

        bus.max_iter = IW'(max_it);
        bus.timeout_frames = TW'(to_lim);
        bus.start = 1; bus.abort = with_abort;
        tick();
        bus.start = 0; bus.abort = 0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.req_dep_img !== 1'b1) begin
            n_errors++;
            $display("FAIL start_accept: busy=%b req_dep_img=%b, expected 1/1", bus.busy, bus.req_dep_img);
        end
        n_checks++;
        if (bus.err_code !== 2'd0 || bus.result_ok !== 1'b0 || bus.iter_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL start_clear: err=%0d ok=%b iter=%0d, expected 0/0/0",
                     bus.err_code, bus.result_ok, bus.iter_cnt);
        end

        exp_iter = 0; to_cnt = 0; nfr = 0; fin = 0;
        while (!fin && nfr < cap) begin
            if (frame_q.size() > 0) f = frame_q.pop_front();
            else if (rnd) f = rand_frame();
            else begin f.ok = 0; f.ss = 0; f.step = 32'sd0; end
            nfr++;

            bus.img_pulse = 1; bus.img_ok = f.ok; bus.img_should_start = f.ss; bus.img_step = f.step;
            tick();
            bus.img_pulse = 0; bus.img_ok = 1'($urandom); bus.img_should_start = 1'($urandom);
            bus.img_step = $urandom;
            st_seen = 0; dn_seen = 0; st_cyc = 0; dn_cyc = 0; busy_after = 1;
            st_dir = 0; st_step = '0; dn_ok = 0; dn_err = '0; dn_iter = '0;
            for (int c = 2; c <= 4; c++) begin
                tick();
                if (bus.m_start === 1'b1) begin
                    st_seen = 1; st_cyc = c; st_dir = bus.m_dir; st_step = bus.m_step;
                end
                if (bus.done === 1'b1) begin
                    dn_seen = 1; dn_cyc = c; dn_ok = bus.result_ok; dn_err = bus.err_code;
                    dn_iter = bus.iter_cnt;
                end
                if (c == 4) busy_after = bus.busy;
            end

            exp_done = 0; exp_ok = 0; exp_err = 2'd0; exp_start = 0;
            if (f.ok) begin
                exp_done = 1; exp_ok = 1; exp_err = 2'd0;
            end else if (f.ss && exp_iter == max_it) begin
                exp_done = 1; exp_err = 2'd1;
            end else if (f.ss) begin
                exp_start = 1;
            end else begin
                to_cnt++;
                if (to_lim != 0 && to_cnt == to_lim) begin
                    exp_done = 1; exp_err = 2'd2;
                end
            end

            n_checks++;
            if (dn_seen !== exp_done || (exp_done && dn_cyc != 2)) begin
                n_errors++;
                $display("FAIL done_strobe frame %0d: seen=%b at cycle %0d, expected seen=%b at cycle 2",
                         nfr, dn_seen, dn_cyc, exp_done);
            end
            n_checks++;
            if (st_seen !== exp_start || (exp_start && st_cyc != 2)) begin
                n_errors++;
                $display("FAIL m_start_strobe frame %0d: seen=%b at cycle %0d, expected seen=%b at cycle 2",
                         nfr, st_seen, st_cyc, exp_start);
            end

            if (exp_done) begin
                fin = 1;
                n_checks++;
                if (dn_ok !== exp_ok || dn_err !== exp_err || dn_iter !== 8'(exp_iter) || busy_after !== 1'b0) begin
                    n_errors++;
                    $display("FAIL done_result: ok=%b err=%0d iter=%0d busy=%b, expected ok=%b err=%0d iter=%0d busy=0",
                             dn_ok, dn_err, dn_iter, busy_after, exp_ok, exp_err, exp_iter);
                end
            end else if (exp_start) begin
                n_checks++;
                if (st_dir !== (f.step < 0) || st_step !== 32'(sat_mag(f.step))) begin
                    n_errors++;
                    $display("FAIL move_cmd: dir=%b step=%h, expected dir=%b step=%h",
                             st_dir, st_step, (f.step < 0), 32'(sat_mag(f.step)));
                end
                exp_iter++;
                to_cnt = 0;
                bus.m_state = 1;
                repeat ($urandom_range(1, 4)) tick();
                bus.m_state = 0;
                repeat (3) tick();
                for (int s = 0; s < SETTLE_N; s++) begin
                    bus.img_pulse = 1; bus.img_ok = 1'($urandom); bus.img_should_start = 1'($urandom);
                    bus.img_step = $urandom; bus.start = 1'($urandom);
                    tick();
                    bus.img_pulse = 0; bus.start = 0;
                    tick();
                end
                tick(); tick();
                n_checks++;
                if (bus.busy !== 1'b1 || bus.req_dep_img !== 1'b1 || bus.iter_cnt !== 8'(exp_iter)) begin
                    n_errors++;
                    $display("FAIL settle_drop: busy=%b req=%b iter=%0d, expected 1/1/%0d",
                             bus.busy, bus.req_dep_img, bus.iter_cnt, exp_iter);
                end
            end
        end

        if (!fin) begin
            bus.abort = 1;
            tick();
            bus.abort = 0;
            n_checks++;
            if (bus.m_stop !== 1'b0 || bus.done !== 1'b0 || bus.err_code !== 2'd3) begin
                n_errors++;
                $display("FAIL abort_wait_img: m_stop=%b done=%b err=%0d, expected 0/0/3",
                         bus.m_stop, bus.done, bus.err_code);
            end
            tick();
            n_checks++;
            if (bus.done !== 1'b1 || bus.result_ok !== 1'b0 || bus.iter_cnt !== 8'(exp_iter)) begin
                n_errors++;
                $display("FAIL abort_done: done=%b ok=%b iter=%0d, expected 1/0/%0d",
                         bus.done, bus.result_ok, bus.iter_cnt, exp_iter);
            end
            tick(); tick();
            n_checks++;
            if (bus.busy !== 1'b0) begin
                n_errors++;
                $display("FAIL abort_idle: busy=%b, expected 0", bus.busy);
            end
        end
        frame_q.delete();
    endtask

    task automatic test_reset();
        drive_idle();
        reset = 1;
        repeat (3) tick();
        n_checks++;
        if ({bus.m_start, bus.m_stop, bus.m_dir, bus.m_step, bus.req_dep_img, bus.busy,
             bus.done, bus.result_ok, bus.err_code, bus.iter_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%0d iter=%0d m_step=%h, expected all 0",
                     bus.busy, bus.done, bus.err_code, bus.iter_cnt, bus.m_step);
        end
        reset = 0;
        tick();
    endtask

    task automatic test_success();
        frame_q.push_back('{ok: 1'b0, ss: 1'b1, step: 32'sd100});
        frame_q.push_back('{ok: 1'b0, ss: 1'b1, step: -32'sd5});
        frame_q.push_back('{ok: 1'b1, ss: 1'b0, step: 32'sd0});
        run_frames(4, 8, 10, 1'b0, 1'b0);
    endtask

    task automatic test_iter_limit();
        repeat (3) frame_q.push_back('{ok: 1'b0, ss: 1'b1, step: 32'sd7});
        run_frames(1, 0, 10, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        repeat (3) frame_q.push_back('{ok: 1'b0, ss: 1'b0, step: 32'sd0});
        run_frames(4, 3, 10, 1'b0, 1'b0);
        run_frames(4, 0, 100, 1'b0, 1'b0);
    endtask

    task automatic test_abort_move_wait();
        bus.max_iter = 8'd4; bus.timeout_frames = '0;
        bus.start = 1; tick(); bus.start = 0;
        bus.img_pulse = 1; bus.img_should_start = 1; bus.img_ok = 0; bus.img_step = 32'sd9;
        tick(); bus.img_pulse = 0; tick();
        n_checks++;
        if (bus.m_start !== 1'b1 || bus.m_step !== 32'd9) begin
            n_errors++;
            $display("FAIL abort_pre_move: m_start=%b m_step=%0d, expected 1/9", bus.m_start, bus.m_step);
        end
        bus.m_state = 1;
        repeat (3) tick();
        bus.abort = 1; tick(); bus.abort = 0;
        n_checks++;
        if (bus.m_stop !== 1'b1 || bus.done !== 1'b0 || bus.err_code !== 2'd3) begin
            n_errors++;
            $display("FAIL abort_m_stop: m_stop=%b done=%b err=%0d, expected 1/0/3",
                     bus.m_stop, bus.done, bus.err_code);
        end
        tick();
        n_checks++;
        if (bus.done !== 1'b1 || bus.m_stop !== 1'b0 || bus.result_ok !== 1'b0 || bus.iter_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL abort_move_done: done=%b m_stop=%b ok=%b iter=%0d, expected 1/0/0/1",
                     bus.done, bus.m_stop, bus.result_ok, bus.iter_cnt);
        end
        bus.m_state = 0;
        tick(); tick();
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_errors++;
            $display("FAIL abort_move_idle: busy=%b, expected 0", bus.busy);
        end
        frame_q.push_back('{ok: 1'b1, ss: 1'b1, step: 32'sd1});
        run_frames(4, 0, 5, 1'b0, 1'b1);
    endtask

    task automatic test_saturation_noack();
        bus.max_iter = 8'd4; bus.timeout_frames = '0;
        bus.start = 1; tick(); bus.start = 0;
        bus.img_pulse = 1; bus.img_should_start = 1; bus.img_ok = 0; bus.img_step = 32'sh80000000;
        tick(); bus.img_pulse = 0; tick();
        n_checks++;
        if (bus.m_start !== 1'b1 || bus.m_step !== 32'h7FFFFFFF || bus.m_dir !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_move: m_start=%b m_step=%h dir=%b, expected 1/7fffffff/1",
                     bus.m_start, bus.m_step, bus.m_dir);
        end
        repeat (ACK_N - 1) tick();
        n_checks++;
        if (bus.req_dep_img !== 1'b0) begin
            n_errors++;
            $display("FAIL noack_early: req_dep_img=%b one cycle before ack window ends, expected 0", bus.req_dep_img);
        end
        tick();
        n_checks++;
        if (bus.req_dep_img !== 1'b1 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL noack_settle: req_dep_img=%b busy=%b at ack window end, expected 1/1",
                     bus.req_dep_img, bus.busy);
        end
        for (int s = 0; s < SETTLE_N; s++) begin
            bus.img_pulse = 1; bus.img_ok = 1; tick(); bus.img_pulse = 0; tick();
        end
        tick(); tick();
        n_checks++;
        if (bus.busy !== 1'b1 || bus.req_dep_img !== 1'b1) begin
            n_errors++;
            $display("FAIL settle_count: busy=%b req=%b after %0d dropped frames, expected 1/1",
                     bus.busy, bus.req_dep_img, SETTLE_N);
        end
        bus.img_pulse = 1; bus.img_ok = 1; tick(); bus.img_pulse = 0; tick();
        n_checks++;
        if (bus.done !== 1'b1 || bus.result_ok !== 1'b1 || bus.err_code !== 2'd0 || bus.iter_cnt !== 8'd1) begin
            n_errors++;
            $display("FAIL sat_done: done=%b ok=%b err=%0d iter=%0d, expected 1/1/0/1",
                     bus.done, bus.result_ok, bus.err_code, bus.iter_cnt);
        end
        bus.img_ok = 0;
        tick(); tick();
    endtask

    task automatic test_reset_settle();
        bus.max_iter = 8'd4; bus.timeout_frames = '0;
        bus.start = 1; tick(); bus.start = 0;
        bus.img_pulse = 1; bus.img_should_start = 1; bus.img_ok = 0; bus.img_step = -32'sd3;
        tick(); bus.img_pulse = 0; tick();
        bus.m_state = 1; tick(); bus.m_state = 0; tick(); tick();
        n_checks++;
        if (bus.req_dep_img !== 1'b1 || bus.busy !== 1'b1) begin
            n_errors++;
            $display("FAIL pre_reset_settle: req=%b busy=%b, expected 1/1", bus.req_dep_img, bus.busy);
        end
        reset = 1; tick(); reset = 0;
        n_checks++;
        if ({bus.m_start, bus.m_stop, bus.m_dir, bus.m_step, bus.req_dep_img, bus.busy,
             bus.done, bus.result_ok, bus.err_code, bus.iter_cnt} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_run: busy=%b req=%b dir=%b m_step=%h iter=%0d, expected all 0",
                     bus.busy, bus.req_dep_img, bus.m_dir, bus.m_step, bus.iter_cnt);
        end
        frame_q.push_back('{ok: 1'b1, ss: 1'b0, step: 32'sd0});
        run_frames(4, 0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 12; r++) begin
            run_frames($urandom_range(0, 4), $urandom_range(0, 5), 40, 1'b1, 1'b0);
            tick();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_success();
        test_iter_limit();
        test_timeout();
        test_abort_move_wait();
        test_saturation_noack();
        test_reset_settle();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
